regfile_wr_sched: RTL and testbench

Write-port scheduler for the ALU register file (`alu_regs`). It shares the single write port (`data_in`, `wrt_slct`, `wrtnbl`) between two requesters: ALU writeback and the load unit. Arbitration is round-robin. After every reset it runs a clear sweep that initialises registers 1..7. It sits between the execute/load stages and `alu_regs`. Read ports are not touched.

---
 rtl/regfile_wr_sched.sv | 119 +++++++++++
 tb/tb_regfile_wr_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for alu_regs: shares the single write port between ALU
// writeback and the load unit (round-robin), after a post-reset clear sweep.
module regfile_wr_sched #(
  parameter bit         INIT_CLEAR = 1'b1,
  parameter logic [7:0] INIT_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_alu,
  input  logic [2:0] alu_addr,
  input  logic [7:0] alu_data,
  output logic       ack_alu,
  input  logic       req_ld,
  input  logic [2:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       ack_ld,
  output logic       init_done,
  output logic [7:0] data_in,
  output logic [6:0] wrt_slct,
  output logic       wrtnbl
);

  // Handshake: a requester holds req/addr/data stable until it samples its
  // one-cycle ack; the ack and the register write share the same cycle, and a
  // requester is not eligible in the cycle its ack is high.

  typedef enum logic {ST_SWEEP, ST_RUN} state_t;
  typedef enum logic {GR_ALU, GR_LD} grant_t;

  // Without the sweep the counter starts at its terminal value, so the very
  // first edge after reset raises init_done.
  localparam logic [3:0] CNT_START = INIT_CLEAR ? 4'd1 : 4'd8;

  state_t     state_q, state_d;
  grant_t     last_q, last_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ack_alu_d, ack_ld_d, init_done_d, wrtnbl_d;
  logic [6:0] wrt_slct_d;
  logic [7:0] data_in_d;
  logic       elig_alu, elig_ld, gnt_alu, gnt_ld;
  logic [2:0] sel_addr;
  logic [7:0] sel_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SWEEP;
      last_q    <= GR_LD;
      cnt_q     <= CNT_START;
      ack_alu   <= 1'b0;
      ack_ld    <= 1'b0;
      init_done <= 1'b0;
      wrtnbl    <= 1'b0;
      wrt_slct  <= 7'b0;
      data_in   <= 8'h00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ack_alu   <= ack_alu_d;
      ack_ld    <= ack_ld_d;
      init_done <= init_done_d;
      wrtnbl    <= wrtnbl_d;
      wrt_slct  <= wrt_slct_d;
      data_in   <= data_in_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ack_alu_d   = 1'b0;
    ack_ld_d    = 1'b0;
    init_done_d = init_done;
    wrtnbl_d    = 1'b0;
    wrt_slct_d  = 7'b0;
    data_in_d   = data_in;
    elig_alu    = req_alu & ~ack_alu;
    elig_ld     = req_ld & ~ack_ld;
    gnt_alu     = 1'b0;
    gnt_ld      = 1'b0;
    sel_addr    = 3'd0;
    sel_data    = 8'h00;

    case (state_q)
      ST_SWEEP: begin
        if (cnt_q == 4'd8) begin
          init_done_d = 1'b1;
          state_d     = ST_RUN;
        end else begin
          wrtnbl_d   = 1'b1;
          wrt_slct_d = 7'b1 << (cnt_q - 4'd1);
          data_in_d  = INIT_VALUE;
          cnt_d      = cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        // On a tie the requester that did not win the previous grant goes first.
        gnt_alu = elig_alu & (~elig_ld | (last_q == GR_LD));
        gnt_ld  = elig_ld & ~gnt_alu;
        if (gnt_alu | gnt_ld) begin
          sel_addr  = gnt_alu ? alu_addr : ld_addr;
          sel_data  = gnt_alu ? alu_data : ld_data;
          last_d    = gnt_alu ? GR_ALU : GR_LD;
          ack_alu_d = gnt_alu;
          ack_ld_d  = gnt_ld;
          data_in_d = sel_data;
          // Register 0 is read-only: the request is acked but nothing is written.
          if (sel_addr != 3'd0) begin
            wrtnbl_d   = 1'b1;
            wrt_slct_d = 7'b1 << (sel_addr - 3'd1);
          end
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Randomised bench for regfile_wr_sched: a cycle-level reference model of the
// scheduling rules feeds an expected-output queue compared every cycle.
module tb_regfile_wr_sched;

  localparam logic [7:0] INIT_VAL = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_alu = 1'b0, req_ld = 1'b0;
  logic [2:0] alu_addr = 3'd0, ld_addr = 3'd0;
  logic [7:0] alu_data = 8'h00, ld_data = 8'h00;
  logic       ack_alu, ack_ld, init_done, wrtnbl;
  logic [6:0] wrt_slct;
  logic [7:0] data_in;

  logic       req0 = 1'b0;
  logic [2:0] addr0 = 3'd0;
  logic [7:0] data0 = 8'h00;
  logic       ack_alu0, ack_ld0, init_done0, wrtnbl0;
  logic [6:0] wrt_slct0;
  logic [7:0] data_in0;

  regfile_wr_sched #(.INIT_CLEAR(1'b1), .INIT_VALUE(INIT_VAL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_alu(req_alu), .alu_addr(alu_addr), .alu_data(alu_data), .ack_alu(ack_alu),
    .req_ld(req_ld), .ld_addr(ld_addr), .ld_data(ld_data), .ack_ld(ack_ld),
    .init_done(init_done), .data_in(data_in), .wrt_slct(wrt_slct), .wrtnbl(wrtnbl)
  );

  regfile_wr_sched #(.INIT_CLEAR(1'b0), .INIT_VALUE(8'h00)) u_dut_noclr (
    .clk(clk), .rst_n(rst_n),
    .req_alu(req0), .alu_addr(addr0), .alu_data(data0), .ack_alu(ack_alu0),
    .req_ld(1'b0), .ld_addr(3'd0), .ld_data(8'h00), .ack_ld(ack_ld0),
    .init_done(init_done0), .data_in(data_in0), .wrt_slct(wrt_slct0), .wrtnbl(wrtnbl0)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Packed outputs: [18] ack_alu [17] ack_ld [16] init_done [15] wrtnbl
  // [14:8] wrt_slct [7:0] data_in
  logic [18:0] exp_q[$];
  logic [18:0] cur_exp;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, first_ack = 0;
  bit          prio_alu = 1'b1;
  bit          rnd_mode = 1'b0, keep_alu = 1'b0, keep_ld = 1'b0;
  logic [7:0]  rf_dut[8], rf_exp[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_outputs", 32'({ack_alu, ack_ld, init_done, wrtnbl, wrt_slct, data_in}), 32'd0);
    check("rst_done_noclr", 32'(init_done0), 32'd0);
    exp_q.delete();
    cur_exp  = '0;
    prio_alu = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // ---------------- reference model ----------------
  // Expected outputs for the next cycle from the current inputs and the acks
  // the model itself expects in the current cycle.
  task automatic predict();
    int         n;
    bit         ea, el, ga, gl;
    logic [2:0] a;
    logic [7:0] d;
    logic [6:0] s;
    n = cyc + 1;
    if (n <= 7) begin
      exp_q.push_back({3'b000, 1'b1, 7'(1 << (n - 1)), INIT_VAL});
    end else if (n == 8) begin
      exp_q.push_back({3'b001, 1'b0, 7'd0, 8'h00});
    end else begin
      ea = req_alu && !cur_exp[18];
      el = req_ld && !cur_exp[17];
      ga = ea && (!el || prio_alu);
      gl = el && !ga;
      a  = ga ? alu_addr : ld_addr;
      d  = ga ? alu_data : ld_data;
      if (ga || gl) prio_alu = gl;
      s  = ((ga || gl) && a != 3'd0) ? 7'(1 << (int'(a) - 1)) : 7'd0;
      exp_q.push_back({ga, gl, 1'b1, (s != 7'd0), s, d});
    end
  endtask

  task automatic tick();
    logic [18:0] got, e;
    @(negedge clk);
    cyc++;
    got = {ack_alu, ack_ld, init_done, wrtnbl, wrt_slct, data_in};
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    cur_exp = e;
    if (!e[15]) begin
      got[7:0] = 8'h00;
      e[7:0]   = 8'h00;
    end
    check("acks_done", 32'(got[18:16]), 32'(e[18:16]));
    check("write_port", 32'(got[15:0]), 32'(e[15:0]));
    for (int i = 1; i < 8; i++) begin
      if (wrtnbl && wrt_slct[i-1]) rf_dut[i] = data_in;
      if (cur_exp[15] && cur_exp[8+i-1]) rf_exp[i] = cur_exp[7:0];
    end
    if (ack_alu && first_ack == 0) first_ack = cyc;
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    if (cur_exp[18]) begin
      if (keep_alu) req_alu = 1'b1;
      else if (rnd_mode && $urandom_range(0, 1) == 1) begin
        alu_addr = 3'($urandom_range(0, 7));
        alu_data = 8'($urandom_range(0, 255));
      end else req_alu = 1'b0;
    end else if (rnd_mode && !req_alu && $urandom_range(0, 2) == 0) begin
      req_alu  = 1'b1;
      alu_addr = 3'($urandom_range(0, 7));
      alu_data = 8'($urandom_range(0, 255));
    end
    if (cur_exp[17]) begin
      if (keep_ld) req_ld = 1'b1;
      else if (rnd_mode && $urandom_range(0, 1) == 1) begin
        ld_addr = 3'($urandom_range(0, 7));
        ld_data = 8'($urandom_range(0, 255));
      end else req_ld = 1'b0;
    end else if (rnd_mode && !req_ld && $urandom_range(0, 2) == 0) begin
      req_ld  = 1'b1;
      ld_addr = 3'($urandom_range(0, 7));
      ld_data = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      drive();
      predict();
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 8; i++) begin
      rf_dut[i] = 8'h00;
      rf_exp[i] = 8'h00;
    end
    #2;
    do_reset();

    // Sweep, plus the no-clear instance answering a request in cycle 2.
    repeat (8) begin
      step(1);
      if (cyc == 1) begin
        check("noclr_done_c1", 32'(init_done0), 32'd1);
        req0 = 1'b1; addr0 = 3'd5; data0 = 8'h5A;
      end else if (cyc == 2) begin
        check("noclr_ack", 32'(ack_alu0), 32'd1);
        check("noclr_write", 32'({wrtnbl0, wrt_slct0, data_in0}), 32'({1'b1, 7'b0010000, 8'h5A}));
        req0 = 1'b0;
      end else if (cyc == 3) begin
        check("noclr_ack_pulse", 32'({ack_alu0, wrtnbl0}), 32'd0);
      end
    end
    check("reg6_after_sweep", 32'(rf_dut[6]), 32'hA5);

    // Single ALU write to register 6.
    req_alu = 1'b1; alu_addr = 3'd6; alu_data = 8'h01;
    step(3);
    check("reg6_alu_write", 32'(rf_dut[6]), 32'h01);

    // Both requesters held continuously.
    req_alu = 1'b1; alu_addr = 3'd1; alu_data = 8'h11; keep_alu = 1'b1;
    req_ld  = 1'b1; ld_addr  = 3'd2; ld_data  = 8'h22; keep_ld  = 1'b1;
    step(8);
    keep_alu = 1'b0; keep_ld = 1'b0;
    step(4);
    check("reg1_alt", 32'(rf_dut[1]), 32'h11);
    check("reg2_alt", 32'(rf_dut[2]), 32'h22);

    // Load to register 0, then a tie that must go to the ALU.
    req_ld = 1'b1; ld_addr = 3'd0; ld_data = 8'hFF;
    step(2);
    req_alu = 1'b1; alu_addr = 3'd3; alu_data = 8'h33;
    req_ld  = 1'b1; ld_addr  = 3'd4; ld_data  = 8'h44;
    step(5);

    // Random traffic.
    rnd_mode = 1'b1;
    step(300);
    rnd_mode = 1'b0;
    step(6);

    // Reset while a write is in flight; the held request survives it.
    req_alu = 1'b1; alu_addr = 3'd7; alu_data = 8'h77;
    for (int k = 0; k < 20 && !cur_exp[15]; k++) step(1);
    do_reset();
    step(12);
    check("reg7_after_rerun", 32'(rf_dut[7]), 32'h77);

    // Request raised during the sweep.
    do_reset();
    step(2);
    req_alu = 1'b1; alu_addr = 3'd3; alu_data = 8'h3C;
    first_ack = 0;
    step(10);
    check("sweep_req_ack_cycle", 32'(first_ack), 32'd9);
    check("reg3_sweep_req", 32'(rf_dut[3]), 32'h3C);

    // More random traffic, then drain and compare the register images.
    rnd_mode = 1'b1;
    step(300);
    rnd_mode = 1'b0;
    step(8);
    for (int i = 1; i < 8; i++) check($sformatf("reg%0d_final", i), 32'(rf_dut[i]), 32'(rf_exp[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
